// File: rtl/cpu_stim_if.sv
// CPU-side bus between the stimulus engine and the pipelined core: bring-up controls,
// instruction fetch port and data memory port.
interface cpu_stim_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              cpu_reset;
    logic              cpu_enable;
    logic              cpu_start;
    logic [ADDR_W-1:0] cpu_i_addr;
    logic [DATA_W-1:0] cpu_i_datain;
    logic [ADDR_W-1:0] cpu_d_addr;
    logic              cpu_d_we;
    logic [DATA_W-1:0] cpu_d_dataout;
    logic [DATA_W-1:0] cpu_d_datain;

    modport master (
        output cpu_reset, cpu_enable, cpu_start, cpu_i_datain, cpu_d_datain,
        input  cpu_i_addr, cpu_d_addr, cpu_d_we, cpu_d_dataout
    );

    modport slave (
        input  cpu_reset, cpu_enable, cpu_start, cpu_i_datain, cpu_d_datain,
        output cpu_i_addr, cpu_d_addr, cpu_d_we, cpu_d_dataout
    );
endinterface

// File: rtl/cpu_stim_engine.sv
// Program/data memory harness that brings up the core, runs it to HALT or timeout and counts
// cycles and stores. Optional store-log FIFO enabled by defining STIM_STORE_LOG_EN.
module cpu_stim_engine #(
    parameter int                DATA_W     = 16,
    parameter int                ADDR_W     = 8,
    parameter int                OPC_W      = 5,
    parameter logic [OPC_W-1:0]  HALT_OPC   = OPC_W'(1),
    parameter int                RST_CYCLES = 2,
    parameter int                DRAIN      = 4,
    parameter int                TIMEOUT    = 4096,
    parameter int                LOG_DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              go,
    cpu_stim_if.master        cpu,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       cycle_cnt,
    output logic [15:0]       store_cnt
`ifdef STIM_STORE_LOG_EN
    ,
    input  logic              log_rd,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [DATA_W-1:0] log_data,
    output logic              log_ovf
`endif
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_ENA, S_STRT, S_RUN, S_DRN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] phase_cnt_q, phase_cnt_d;
    logic [15:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic [DATA_W-1:0] imem_q [DEPTH];
    logic [DATA_W-1:0] dmem_q [DEPTH];

    logic              active, busy_int, go_acc, halt_seen, tmo_hit, store_ok;
    logic              imem_we, dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata;

    assign cpu.cpu_i_datain = imem_q[cpu.cpu_i_addr];
    assign cpu.cpu_d_datain = dmem_q[cpu.cpu_d_addr];

    always_comb begin
        active    = (state_q == S_RUN) || (state_q == S_DRN);
        busy_int  = (state_q != S_IDLE) && (state_q != S_DONE);
        go_acc    = go && !busy_int;
        halt_seen = (state_q == S_RUN) &&
                    (cpu.cpu_i_datain[DATA_W-1 -: OPC_W] == HALT_OPC);
        tmo_hit   = active && (cycle_cnt_q == 16'(TIMEOUT - 1));
        store_ok  = active && cpu.cpu_d_we;
        // Core stores and loader writes share the DMEM port; they are never live together.
        imem_we    = load_en && !busy_int && !load_sel;
        dmem_we    = store_ok || (load_en && !busy_int && load_sel);
        dmem_waddr = store_ok ? cpu.cpu_d_addr    : load_addr;
        dmem_wdata = store_ok ? cpu.cpu_d_dataout : load_data;
    end

    always_ff @(posedge clock) begin
        if (imem_we) imem_q[load_addr]  <= load_data;
        if (dmem_we) dmem_q[dmem_waddr] <= dmem_wdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            phase_cnt_q <= '0;
            cycle_cnt_q <= '0;
            store_cnt_q <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_cnt_q <= phase_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            store_cnt_q <= store_cnt_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d     = S_RST;
                    phase_cnt_d = '0;
                end
            end
            S_RST: begin
                if (phase_cnt_q == 16'(RST_CYCLES - 1)) state_d = S_ENA;
                else                                    phase_cnt_d = phase_cnt_q + 16'd1;
            end
            S_ENA:  state_d = S_STRT;
            S_STRT: state_d = S_RUN;
            S_RUN: begin
                // Timeout takes priority over a HALT fetched in the same cycle.
                if (tmo_hit) begin
                    state_d = S_DONE;
                end else if (halt_seen) begin
                    state_d     = (DRAIN == 0) ? S_DONE : S_DRN;
                    phase_cnt_d = '0;
                end
            end
            S_DRN: begin
                if (tmo_hit || (phase_cnt_q == 16'(DRAIN - 1))) state_d = S_DONE;
                else                                            phase_cnt_d = phase_cnt_q + 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        store_cnt_d = store_cnt_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        if (go_acc) begin
            cycle_cnt_d = '0;
            store_cnt_d = '0;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
        end else begin
            if (active && (cycle_cnt_q != 16'hFFFF)) cycle_cnt_d = cycle_cnt_q + 16'd1;
            if (store_ok && (store_cnt_q != 16'hFFFF)) store_cnt_d = store_cnt_q + 16'd1;
            if (active && (state_d == S_DONE)) begin
                done_d    = 1'b1;
                timeout_d = tmo_hit;
            end
        end
    end

    always_comb begin
        cpu.cpu_reset  = (state_q == S_RST);
        cpu.cpu_enable = (state_q == S_ENA) || (state_q == S_STRT) ||
                         (state_q == S_RUN) || (state_q == S_DRN);
        cpu.cpu_start  = (state_q == S_STRT);
        busy           = busy_int;
        done           = done_q;
        timeout        = timeout_q;
        cycle_cnt      = cycle_cnt_q;
        store_cnt      = store_cnt_q;
    end

`ifdef STIM_STORE_LOG_EN
    localparam int LOG_AW = $clog2(LOG_DEPTH);

    logic [ADDR_W+DATA_W-1:0] log_mem_q [LOG_DEPTH];
    logic [LOG_AW-1:0]        log_wp_q, log_wp_d;
    logic [LOG_AW-1:0]        log_rp_q, log_rp_d;
    logic [LOG_AW:0]          log_cnt_q, log_cnt_d;
    logic                     log_ovf_q, log_ovf_d;
    logic                     log_full, log_push, log_pop;

    always_comb begin
        log_full  = (log_cnt_q == (LOG_AW + 1)'(LOG_DEPTH));
        log_pop   = log_rd && (log_cnt_q != '0);
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        log_push  = store_ok && (!log_full || log_pop);
        log_wp_d  = log_wp_q;
        log_rp_d  = log_rp_q;
        log_cnt_d = log_cnt_q;
        log_ovf_d = log_ovf_q;
        if (go_acc) begin
            log_wp_d  = '0;
            log_rp_d  = '0;
            log_cnt_d = '0;
            log_ovf_d = 1'b0;
        end else begin
            if (log_push) log_wp_d = log_wp_q + 1'b1;
            if (log_pop)  log_rp_d = log_rp_q + 1'b1;
            if (log_push && !log_pop)      log_cnt_d = log_cnt_q + 1'b1;
            else if (!log_push && log_pop) log_cnt_d = log_cnt_q - 1'b1;
            if (store_ok && !log_push)     log_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (log_push) log_mem_q[log_wp_q] <= {cpu.cpu_d_addr, cpu.cpu_d_dataout};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            log_wp_q  <= '0;
            log_rp_q  <= '0;
            log_cnt_q <= '0;
            log_ovf_q <= 1'b0;
        end else begin
            log_wp_q  <= log_wp_d;
            log_rp_q  <= log_rp_d;
            log_cnt_q <= log_cnt_d;
            log_ovf_q <= log_ovf_d;
        end
    end

    assign log_valid            = (log_cnt_q != '0);
    assign {log_addr, log_data} = log_mem_q[log_rp_q];
    assign log_ovf              = log_ovf_q;
`endif
endmodule
